// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin burst arbiter sharing one synchronous-read ROM
// between N_REQ requesters. Each grant issues REQ_LEN+1 consecutive ROM
// addresses; the returned words are routed to the owner with RSP_VALID pulses
// one cycle after each issue (ROM DOUT is registered).
// Optional feature macro: ROM_ARB_STATS_EN (per-requester saturating word
// counters with a registered read port STAT_SEL/STAT_CNT).
module rom_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            REQ_VALID,
    input  logic [N_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [N_REQ*LEN_WIDTH-1:0]  REQ_LEN,
    output logic [N_REQ-1:0]            REQ_READY,
    output logic [N_REQ-1:0]            RSP_VALID,
    output logic [DATA_WIDTH-1:0]       RSP_DATA,
    output logic                        BUSY,
    output logic [ADDR_WIDTH-1:0]       ROM_ADDR,
    input  logic [DATA_WIDTH-1:0]       ROM_DOUT
`ifdef ROM_ARB_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0]    STAT_SEL,
    output logic [15:0]                 STAT_CNT
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [N_REQ-1:0]       rsp_pend_q, rsp_pend_d;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    int unsigned            scan_idx;

    // Round-robin search: first set REQ_VALID bit from rr_q upward, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (32'(rr_q) + k) % N_REQ;
            if (!win_found && REQ_VALID[IDX_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: a grant starts a burst; the last issue cycle ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = BURST;
            BURST:   if (rem_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the granted burst, then step the address.
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        rsp_pend_d = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    addr_d  = REQ_ADDR[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    rem_d   = REQ_LEN[win_idx*LEN_WIDTH +: LEN_WIDTH];
                    owner_d = win_idx;
                    rr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                end
            end
            BURST: begin
                // The word addressed this cycle returns next cycle.
                rsp_pend_d = N_REQ'(1) << owner_q;
                if (rem_q != '0) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            rem_q      <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            rsp_pend_q <= '0;
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end

    // Outputs: grant is combinational and suppressed during reset.
    always_comb begin
        REQ_READY = '0;
        if (state_q == IDLE && win_found && !rst)
            REQ_READY = N_REQ'(1) << win_idx;
        RSP_VALID = rsp_pend_q;
        RSP_DATA  = ROM_DOUT;
        BUSY      = (state_q == BURST);
        ROM_ADDR  = addr_q;
    end

`ifdef ROM_ARB_STATS_EN
    logic [15:0] cnt_q [N_REQ];
    logic [15:0] stat_q;

    // Per-requester saturating word counters and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
            stat_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++)
                if (rsp_pend_q[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 16'd1;
            stat_q <= cnt_q[STAT_SEL];
        end
    end

    assign STAT_CNT = stat_q;
`endif

endmodule
